// File: rtl/pe_pkg.sv
// Shared types for the PE reducer feed path: address triples, feed entries
// and the grouping FSM states.
package pe_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;

  typedef logic [2:0][ADDR_W-1:0] addr3_t;

  typedef struct packed {
    addr3_t                   addr;
    logic signed [DATA_W-1:0] w;
    logic signed [DATA_W-1:0] ia;
    logic                     last;
  } feed_entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } feed_state_e;

  // Filler slot: merges into the given address with zero contribution.
  function automatic feed_entry_t pad_entry(input addr3_t addr);
    feed_entry_t e;
    e.addr = addr;
    e.w    = {DATA_W{1'b0}};
    e.ia   = {DATA_W{1'b0}};
    e.last = 1'b0;
    return e;
  endfunction
endpackage

// File: rtl/pe_feed_fifo.sv
// In-order entry buffer with a three-deep lookahead window and a 0..3 pop per
// cycle; count and ready are both registered.
module pe_feed_fifo
  import pe_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  feed_entry_t            i_entry,
  input  logic [1:0]             i_pop_cnt,
  output feed_entry_t            o_peek [3],
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  feed_entry_t   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          ready_r;
  logic          push_s;

  // Accept decision, next occupancy and the lookahead window.
  always_comb begin
    push_s       = i_valid & ready_r;
    count_next_s = count_r + CW'(push_s) - CW'(i_pop_cnt);
    for (int i = 0; i < 3; i++) begin
      o_peek[i] = mem_r[rd_ptr_r + PW'(i)];
    end
  end

  // Storage, pointers (wrap naturally at DEPTH) and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {$bits(feed_entry_t){1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      ready_r  <= 1'b1;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= i_entry;
        wr_ptr_r        <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      rd_ptr_r <= rd_ptr_r + PW'(i_pop_cnt);
      count_r  <= count_next_s;
      ready_r  <= (count_next_s < CW'(DEPTH));
    end
  end

  assign o_count = count_r;
  assign o_ready = ready_r;
endmodule

// File: rtl/pe_triple_feeder.sv
// Packs buffered feed entries into groups of three (tile-end closes a group
// early, padded with zero-weight copies of its last address) for the reducer.
module pe_triple_feeder
  import pe_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  addr3_t                   i_addr,
  input  logic signed [DATA_W-1:0] i_w,
  input  logic signed [DATA_W-1:0] i_ia,
  input  logic                     i_last,
  output logic                     o_start,
  output addr3_t                   o_addr [3],
  output logic signed [DATA_W-1:0] o_w [3],
  output logic signed [DATA_W-1:0] o_ia [3],
  input  logic                     i_red_finish,
  output logic                     o_tile_done,
  output logic                     o_busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  feed_entry_t   entry_s;
  feed_entry_t   peek_s [3];
  feed_entry_t   slot_s [3];
  feed_entry_t   grp_r [3];
  addr3_t        pad_addr_s;
  logic [CW-1:0] count_s;
  logic [2:0]    lastv_s;
  logic [1:0]    k_s;
  logic [1:0]    pop_cnt_s;
  logic          found_s;
  logic          issue_s;
  feed_state_e   state_r;
  logic          start_r;
  logic          busy_r;
  logic          tile_done_r;
  logic          grp_last_r;

  pe_feed_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .i_entry   (entry_s),
    .i_pop_cnt (pop_cnt_s),
    .o_peek    (peek_s),
    .o_count   (count_s),
    .o_ready   (o_ready)
  );

  // Group size: up to and including the first valid last flag, else three.
  always_comb begin
    entry_s = '{addr: i_addr, w: i_w, ia: i_ia, last: i_last};
    for (int i = 0; i < 3; i++) begin
      lastv_s[i] = (count_s > CW'(i)) && peek_s[i].last;
    end
    found_s = |lastv_s;
    if (lastv_s[0]) begin
      k_s = 2'd1;
    end else if (lastv_s[1]) begin
      k_s = 2'd2;
    end else begin
      k_s = 2'd3;
    end
    issue_s   = (state_r == S_IDLE) && ((count_s >= CW'(3)) || found_s);
    pop_cnt_s = issue_s ? k_s : 2'd0;
  end

  // Slot contents for an issue, padding past the group's last real entry.
  always_comb begin
    case (k_s)
      2'd1:    pad_addr_s = peek_s[0].addr;
      2'd2:    pad_addr_s = peek_s[1].addr;
      default: pad_addr_s = peek_s[2].addr;
    endcase
    for (int j = 0; j < 3; j++) begin
      if (2'(j) < k_s) begin
        slot_s[j] = peek_s[j];
      end else begin
        slot_s[j] = pad_entry(pad_addr_s);
      end
    end
  end

  // Grouping FSM with registered handshake outputs and held group slots.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= S_IDLE;
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
      tile_done_r <= 1'b0;
      grp_last_r  <= 1'b0;
      for (int j = 0; j < 3; j++) begin
        grp_r[j] <= {$bits(feed_entry_t){1'b0}};
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          tile_done_r <= 1'b0;
          if (issue_s) begin
            for (int j = 0; j < 3; j++) begin
              grp_r[j] <= slot_s[j];
            end
            grp_last_r <= found_s;
            start_r    <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= S_WAIT;
          end else begin
            start_r <= 1'b0;
          end
        end
        S_WAIT: begin
          start_r <= 1'b0;
          if (i_red_finish) begin
            busy_r      <= 1'b0;
            tile_done_r <= grp_last_r;
            state_r     <= grp_last_r ? S_DONE : S_IDLE;
          end else begin
            busy_r <= 1'b1;
          end
        end
        S_DONE: begin
          tile_done_r <= 1'b0;
          state_r     <= S_IDLE;
        end
        default: begin
          start_r     <= 1'b0;
          busy_r      <= 1'b0;
          tile_done_r <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    for (int j = 0; j < 3; j++) begin
      o_addr[j] = grp_r[j].addr;
      o_w[j]    = grp_r[j].w;
      o_ia[j]   = grp_r[j].ia;
    end
  end

  assign o_start     = start_r;
  assign o_busy      = busy_r;
  assign o_tile_done = tile_done_r;
endmodule

// File: tb/tb_pe_triple_feeder.sv
// Bench for pe_triple_feeder: queue-based reference model, reducer model
// answering two cycles after start, directed tile scenarios plus random traffic.
module tb_pe_triple_feeder;
  import pe_pkg::*;

  logic                     i_clk = 1'b0;
  logic                     i_rst_n = 1'b0;
  logic                     i_valid = 1'b0;
  logic                     o_ready;
  addr3_t                   i_addr = 21'd0;
  logic signed [DATA_W-1:0] i_w = 16'sd0;
  logic signed [DATA_W-1:0] i_ia = 16'sd0;
  logic                     i_last = 1'b0;
  logic                     o_start;
  addr3_t                   o_addr [3];
  logic signed [DATA_W-1:0] o_w [3];
  logic signed [DATA_W-1:0] o_ia [3];
  logic                     i_red_finish = 1'b0;
  logic                     o_tile_done;
  logic                     o_busy;

  pe_triple_feeder #(.FIFO_DEPTH(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_addr(i_addr), .i_w(i_w), .i_ia(i_ia), .i_last(i_last),
    .o_start(o_start), .o_addr(o_addr), .o_w(o_w), .o_ia(o_ia),
    .i_red_finish(i_red_finish), .o_tile_done(o_tile_done), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the accepted-but-unissued entries, the held group,
  // and the expected handshake outputs after the next edge.
  feed_entry_t m_q[$];
  feed_entry_t m_grp [3];
  int          m_phase;
  bit          m_last;
  bit          e_start, e_busy, e_done, e_ready;

  bit hold, spur, pend;
  int age;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("flags(start,busy,done,ready)", {60'd0, o_start, o_busy, o_tile_done, o_ready},
        {60'd0, e_start, e_busy, e_done, e_ready});
    chk("grp_addr", {1'b0, o_addr[0], o_addr[1], o_addr[2]},
        {1'b0, m_grp[0].addr, m_grp[1].addr, m_grp[2].addr});
    chk("grp_w", {16'd0, o_w[0], o_w[1], o_w[2]}, {16'd0, m_grp[0].w, m_grp[1].w, m_grp[2].w});
    chk("grp_ia", {16'd0, o_ia[0], o_ia[1], o_ia[2]}, {16'd0, m_grp[0].ia, m_grp[1].ia, m_grp[2].ia});
  endtask

  function automatic feed_entry_t ent(input int a, input int w, input int ia, input bit l);
    feed_entry_t e;
    logic [20:0] t;
    t      = 21'(a);
    e.addr = t;
    e.w    = 16'(w);
    e.ia   = 16'(ia);
    e.last = l;
    return e;
  endfunction

  // What the next clock edge should do, computed from the tile rules.
  task automatic model_edge();
    int n, k;
    bit found;
    feed_entry_t e;
    n = m_q.size();
    e_start = 1'b0;
    case (m_phase)
      0: begin
        found = 1'b0;
        k = 3;
        for (int i = 0; i < 3 && i < n; i++) begin
          if (!found && m_q[i].last) begin
            found = 1'b1;
            k = i + 1;
          end
        end
        if (n >= 3 || found) begin
          for (int j = 0; j < 3; j++) begin
            if (j < k) m_grp[j] = m_q[j];
            else m_grp[j] = ent(0, 0, 0, 1'b0);
            if (j >= k) m_grp[j].addr = m_q[k-1].addr;
          end
          for (int j = 0; j < k; j++) void'(m_q.pop_front());
          e_start = 1'b1;
          e_busy  = 1'b1;
          m_last  = found;
          m_phase = 1;
        end
      end
      1: begin
        if (i_red_finish) begin
          e_busy  = 1'b0;
          e_done  = m_last;
          m_phase = m_last ? 2 : 0;
        end
      end
      2: begin
        e_done  = 1'b0;
        m_phase = 0;
      end
      default: m_phase = 0;
    endcase
    if (i_valid && n < 8) begin
      e.addr = i_addr; e.w = i_w; e.ia = i_ia; e.last = i_last;
      m_q.push_back(e);
    end
    e_ready = (m_q.size() < 8);
  endtask

  task automatic cycle(input bit v, input feed_entry_t e);
    @(negedge i_clk);
    i_red_finish = 1'b0;
    if (pend) begin
      age++;
      if (age >= 2 && !hold) begin
        i_red_finish = 1'b1;
        pend = 1'b0;
      end
    end else if (spur && !o_start && $urandom_range(0, 7) == 0) begin
      i_red_finish = 1'b1;
    end
    if (o_start) begin
      pend = 1'b1;
      age  = 0;
    end
    i_valid = v;
    i_addr  = e.addr;
    i_w     = e.w;
    i_ia    = e.ia;
    i_last  = e.last;
    model_edge();
    @(posedge i_clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, ent(0, 0, 0, 1'b0));
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_red_finish = 1'b0;
    hold = 1'b0;
    pend = 1'b0;
    m_q.delete();
    m_phase = 0;
    for (int j = 0; j < 3; j++) m_grp[j] = ent(0, 0, 0, 1'b0);
    e_start = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_ready = 1'b1;
    #1;
    check_outputs();
    @(posedge i_clk);
    #1;
    check_outputs();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    hold = 1'b0; spur = 1'b0; pend = 1'b0; age = 0;
    do_reset();

    // Two full groups, no tile end.
    for (int i = 1; i <= 6; i++) cycle(1'b1, ent(i, i, 2 * i, 1'b0));
    idle(12);

    // Two-entry tile: slot 2 padded from addr 11.
    cycle(1'b1, ent(10, 3, 5, 1'b0));
    cycle(1'b1, ent(11, 4, 6, 1'b1));
    idle(8);

    // Last on the first of five entries; the fifth waits for more data.
    for (int i = 1; i <= 5; i++) cycle(1'b1, ent(20 + i, i, -i, i == 1));
    idle(16);
    cycle(1'b1, ent(30, 7, 7, 1'b1));
    idle(10);

    // Reducer stalled while the upstream keeps pushing: FIFO fills.
    hold = 1'b1;
    for (int i = 0; i < 12; i++) cycle(1'b1, ent(40 + i, 100 + i, -100 - i, 1'b0));
    hold = 1'b0;
    idle(30);
    cycle(1'b1, ent(60, 1, 1, 1'b1));
    idle(10);

    // Reset while a group is outstanding with four entries buffered.
    hold = 1'b1;
    for (int i = 0; i < 7; i++) cycle(1'b1, ent(70 + i, i, i, 1'b0));
    idle(2);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, ent(80 + i, 9 + i, 3, 1'b0));
    idle(8);

    // Push landing in the issue cycle of a three-entry FIFO.
    for (int i = 0; i < 4; i++) cycle(1'b1, ent(90 + i, -5 - i, 2, 1'b0));
    idle(6);
    cycle(1'b1, ent(95, 8, 8, 1'b1));
    idle(10);

    // Random traffic with spurious finish pulses outside the wait state.
    spur = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cycle(1'(($urandom_range(0, 2)) != 0),
            ent(int'($urandom_range(0, 2097151)), int'($urandom), int'($urandom),
                $urandom_range(0, 3) == 0));
    end
    spur = 1'b0;
    cycle(1'b1, ent(127, 1, 1, 1'b1));
    idle(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
